// File: rtl/xdma_pkg.sv
// Shared definitions for the xdma controller: register map, control/status bits, FSM states.
package xdma_pkg;

    localparam logic [1:0] RegAddr   = 2'd0;
    localparam logic [1:0] RegLen    = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlDirBit   = 1;
    localparam int unsigned CtrlAbortBit = 2;

    localparam int unsigned StatBusyBit = 0;
    localparam int unsigned StatDoneBit = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRd    = 2'd1,
        StWr    = 2'd2,
        StDrain = 2'd3
    } xdma_state_e;

endpackage

// File: rtl/xdma_skid.sv
// Two-entry FIFO holding RAM read data until the outbound stream accepts it.
module xdma_skid #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/xdma_ctrl.sv
// DMA engine moving LEN words between the shared RAM port and a valid/ready word stream.
module xdma_ctrl
    import xdma_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_sel,
    input  logic              ctrl_we,
    input  logic [1:0]        ctrl_addr,
    input  logic [DATA_W-1:0] ctrl_data_in,
    output logic [DATA_W-1:0] ctrl_data_out,
    input  logic              dma_gnt,
    output logic              dma_sel,
    output logic              dma_we,
    output logic [MEM_AW-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_data_in,
    input  logic [DATA_W-1:0] dma_data_out,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              done
);

    xdma_state_e       state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d, cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  len_q, len_d, iss_q, iss_d, rem_q, rem_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              dir_q, dir_d, done_q, done_d, rd_pend_q, rd_pend_d;

    logic              wr_strobe, rd_strobe, ctrl_wr, abort, start, busy, accept;
    logic              skid_empty, skid_pop, unused_skid_full, unused_ctrl_data;
    logic [1:0]        skid_count;
    logic [2:0]        occ;

    assign wr_strobe = ctrl_sel & ctrl_we;
    assign rd_strobe = ctrl_sel & ~ctrl_we;
    assign ctrl_wr   = wr_strobe && (ctrl_addr == RegCtrl);
    assign abort     = ctrl_wr & ctrl_data_in[CtrlAbortBit];
    assign start     = ctrl_wr & ctrl_data_in[CtrlStartBit] & ~abort & (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign accept    = dma_sel & dma_gnt;
    assign skid_pop  = ~skid_empty & m_ready;
    assign m_valid   = ~skid_empty;
    assign dma_addr  = cur_addr_q;
    assign done      = done_q;
    assign ctrl_data_out    = rdata_q;
    assign unused_ctrl_data = ^ctrl_data_in;

    // Skid entries plus the read in flight, after this cycle's pop; a new read may only
    // be issued if its data is guaranteed a free slot when it arrives.
    assign occ = {1'b0, skid_count} + {2'b00, rd_pend_q} - {2'b00, skid_pop};

    xdma_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort),
        .push     (rd_pend_q),
        .push_data(dma_data_out),
        .pop      (skid_pop),
        .head     (m_data),
        .full     (unused_skid_full),
        .empty    (skid_empty),
        .count    (skid_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start && len_q != '0) state_d = ctrl_data_in[CtrlDirBit] ? StWr : StRd;
                StWr:    if (accept && rem_q == LEN_W'(1)) state_d = StIdle;
                StRd:    if (accept && iss_q == LEN_W'(1)) state_d = StDrain;
                StDrain: if (skid_pop && rem_q == LEN_W'(1)) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        dma_sel     = 1'b0;
        dma_we      = 1'b0;
        s_ready     = 1'b0;
        dma_data_in = '0;
        unique case (state_q)
            StWr: begin
                dma_sel     = s_valid;
                dma_we      = 1'b1;
                s_ready     = dma_gnt;
                dma_data_in = s_data;
            end
            StRd:    dma_sel = (occ < 3'd2);
            default: ;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        cur_addr_d = cur_addr_q;
        iss_d      = iss_q;
        rem_d      = rem_q;
        dir_d      = dir_q;
        done_d     = done_q;
        rdata_d    = rdata_q;
        rd_pend_d  = accept & ~dma_we & ~abort;

        if (rd_strobe) begin
            rdata_d = '0;
            unique case (ctrl_addr)
                RegAddr: rdata_d = DATA_W'(addr_q);
                RegLen:  rdata_d = DATA_W'(len_q);
                RegCtrl: rdata_d[CtrlDirBit] = dir_q;
                default: begin
                    rdata_d[StatBusyBit] = busy;
                    rdata_d[StatDoneBit] = done_q;
                    done_d               = 1'b0;
                end
            endcase
        end

        if (wr_strobe && !busy) begin
            if (ctrl_addr == RegAddr) addr_d = ctrl_data_in[MEM_AW-1:0];
            if (ctrl_addr == RegLen)  len_d  = ctrl_data_in[LEN_W-1:0];
        end

        if (accept) cur_addr_d = cur_addr_q + MEM_AW'(1);

        if (state_q == StWr && accept) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1) && !abort) done_d = 1'b1;
        end
        if (state_q == StRd && accept) iss_d = iss_q - LEN_W'(1);
        if ((state_q == StRd || state_q == StDrain) && skid_pop) begin
            rem_d = rem_q - LEN_W'(1);
            if (state_q == StDrain && rem_q == LEN_W'(1) && !abort) done_d = 1'b1;
        end

        if (start) begin
            dir_d      = ctrl_data_in[CtrlDirBit];
            cur_addr_d = addr_q;
            rem_d      = len_q;
            iss_d      = len_q;
            done_d     = (len_q == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            cur_addr_q <= '0;
            iss_q      <= '0;
            rem_q      <= '0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            len_q      <= len_d;
            cur_addr_q <= cur_addr_d;
            iss_q      <= iss_d;
            rem_q      <= rem_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            rd_pend_q  <= rd_pend_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_xdma_ctrl.sv
// Self-checking bench for xdma_ctrl: register vectors, a RAM model and stream scoreboards.
`timescale 1ns/1ps
module tb_xdma_ctrl;
    import xdma_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_sel, ctrl_we;
    logic [1:0]    ctrl_addr;
    logic [DW-1:0] ctrl_data_in, ctrl_data_out;
    logic          dma_gnt, dma_sel, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_data_in;
    logic [DW-1:0] rdata = '0;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          done;

    always #5 clk = ~clk;

    xdma_ctrl #(.DATA_W(DW), .MEM_AW(AW), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_sel     (ctrl_sel),
        .ctrl_we      (ctrl_we),
        .ctrl_addr    (ctrl_addr),
        .ctrl_data_in (ctrl_data_in),
        .ctrl_data_out(ctrl_data_out),
        .dma_gnt      (dma_gnt),
        .dma_sel      (dma_sel),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_data_in  (dma_data_in),
        .dma_data_out (rdata),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .done         (done)
    );

    // RAM model with registered read data; preload port used only while the DUT is idle.
    logic [DW-1:0] ram [0:4095];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (dma_sel && dma_gnt) begin
            if (dma_we) ram[dma_addr] <= dma_data_in;
            else rdata <= ram[dma_addr];
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic          we;
        logic [1:0]    addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } reg_vec_t;

    int            checks = 0;
    int            failures = 0;
    wr_t           wr_q[$];
    logic [DW-1:0] rd_q[$];
    bit            rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [DW-1:0] d);
        ctrl_sel = 1'b1; ctrl_we = 1'b1; ctrl_addr = a; ctrl_data_in = d;
        @(posedge clk); #1;
        ctrl_sel = 1'b0; ctrl_we = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [DW-1:0] d);
        ctrl_sel = 1'b1; ctrl_we = 1'b0; ctrl_addr = a;
        @(posedge clk); #1;
        ctrl_sel = 1'b0;
        d = ctrl_data_out;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic run_wr(input logic [AW-1:0] base, input int n, input logic [DW-1:0] seed,
                          input int stall_at);
        int            i = 0;
        int            stalls = 0;
        logic          acc;
        logic [DW-1:0] rd;
        reg_wr(RegAddr, DW'(base));
        reg_wr(RegLen, DW'(n));
        for (int k = 0; k < n; k++) wr_q.push_back('{a: AW'(int'(base) + k), d: seed + DW'(k)});
        reg_wr(RegCtrl, 32'h3);
        s_valid = 1'b1;
        for (int c = 0; c < 100 && i < n; c++) begin
            s_data  = seed + DW'(i);
            dma_gnt = !(i == stall_at && stalls < 3);
            @(negedge clk);
            acc = s_ready;
            if (!dma_gnt) begin
                stalls++;
                check("stall_s_ready", DW'(s_ready), '0);
                check("stall_addr", DW'(dma_addr), DW'(AW'(int'(base) + stall_at)));
            end
            @(posedge clk); #1;
            if (acc) i++;
        end
        s_valid = 1'b0;
        dma_gnt = 1'b1;
        check("wr_beats", DW'(i), DW'(n));
        check("wr_done", DW'(done), 32'd1);
        check("wr_sb_empty", DW'(wr_q.size()), '0);
        for (int k = 0; k < n; k++) check("wr_ram", ram[AW'(int'(base) + k)], seed + DW'(k));
        reg_rd(RegStatus, rd);
        check("wr_status", rd, 32'h2);
        reg_rd(RegStatus, rd);
        check("wr_status_clr", rd, 32'h0);
    endtask

    // Reads ram[base+k] == k into the stream; toggle applies the 1,0,0,1 m_ready pattern.
    task automatic run_rd(input logic [AW-1:0] base, input int n, input bit toggle);
        int            first_acc = -1, first_mv = -1, first_pop = -1, last_pop = -1;
        int            issued = 0, popped = 0;
        logic [DW-1:0] rd;
        reg_wr(RegAddr, DW'(base));
        reg_wr(RegLen, DW'(n));
        for (int k = 0; k < n; k++) rd_q.push_back(DW'(k));
        m_ready = 1'b1;
        reg_wr(RegCtrl, 32'h1);
        for (int c = 0; c < 200 && popped < n; c++) begin
            @(negedge clk);
            if (dma_sel && dma_gnt) begin
                if (first_acc < 0) first_acc = c;
                issued++;
            end
            if (m_valid && first_mv < 0) first_mv = c;
            if (m_valid && m_ready) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                popped++;
            end
            check("rd_outstanding", DW'(issued - popped > 2), '0);
            @(posedge clk); #1;
            if (toggle) m_ready = rdy_pat[(c + 1) % 4];
        end
        check("rd_beats", DW'(popped), DW'(n));
        check("rd_issued", DW'(issued), DW'(n));
        check("rd_sb_empty", DW'(rd_q.size()), '0);
        if (!toggle) begin
            check("rd_latency", DW'(first_mv - first_acc), 32'd2);
            check("rd_no_gaps", DW'(last_pop - first_pop), DW'(n - 1));
        end
        check("rd_done", DW'(done), 32'd1);
        m_ready = 1'b0;
        reg_rd(RegStatus, rd);
        check("rd_status", rd, 32'h2);
    endtask

    initial begin : monitor
        wr_t           e;
        logic [DW-1:0] x;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dma_sel && dma_gnt && dma_we) begin
                    if (wr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wr_extra: write 0x%0h to 0x%0h, none required",
                                 dma_data_in, dma_addr);
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_addr", DW'(dma_addr), DW'(e.a));
                        check("wr_data", dma_data_in, e.d);
                    end
                end
                if (m_valid && m_ready) begin
                    if (rd_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL m_extra: beat 0x%0h, none required", m_data);
                    end else begin
                        x = rd_q.pop_front();
                        check("m_data", m_data, x);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        reg_vec_t      vec [12];
        logic [DW-1:0] rd;
        int            popped;

        vec[0]  = '{we: 1'b0, addr: RegStatus, wdata: '0,           exp: 32'h0};
        vec[1]  = '{we: 1'b0, addr: RegAddr,   wdata: '0,           exp: 32'h0};
        vec[2]  = '{we: 1'b0, addr: RegLen,    wdata: '0,           exp: 32'h0};
        vec[3]  = '{we: 1'b1, addr: RegAddr,   wdata: 32'h123,      exp: '0};
        vec[4]  = '{we: 1'b0, addr: RegAddr,   wdata: '0,           exp: 32'h123};
        vec[5]  = '{we: 1'b1, addr: RegLen,    wdata: 32'hFFFF_F0AB, exp: '0};
        vec[6]  = '{we: 1'b0, addr: RegLen,    wdata: '0,           exp: 32'h0AB};
        vec[7]  = '{we: 1'b1, addr: RegAddr,   wdata: 32'hABCD_E456, exp: '0};
        vec[8]  = '{we: 1'b0, addr: RegAddr,   wdata: '0,           exp: 32'h456};
        vec[9]  = '{we: 1'b1, addr: RegCtrl,   wdata: 32'h5,        exp: '0};
        vec[10] = '{we: 1'b0, addr: RegStatus, wdata: '0,           exp: 32'h0};
        vec[11] = '{we: 1'b0, addr: RegLen,    wdata: '0,           exp: 32'h0AB};

        rst = 1'b1; ctrl_sel = 1'b0; ctrl_we = 1'b0; ctrl_addr = '0; ctrl_data_in = '0;
        dma_gnt = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", DW'({dma_sel, dma_we, s_ready, m_valid, done}), '0);
        check("rst_addr", DW'(dma_addr), '0);
        check("rst_m_data", m_data, '0);
        check("rst_rdata", ctrl_data_out, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            if (vec[i].we) reg_wr(vec[i].addr, vec[i].wdata);
            else begin
                reg_rd(vec[i].addr, rd);
                check($sformatf("reg_vec%0d", i), rd, vec[i].exp);
            end
        end

        run_wr(12'h010, 4, 32'h0000_00A0, -1);
        run_wr(12'h100, 6, 32'h5500_0000, 2);
        run_wr(12'hFFE, 4, 32'hC0DE_0000, -1);

        for (int k = 0; k < 8; k++) preload(AW'(12'h020 + k), DW'(k));
        run_rd(12'h020, 8, 1'b0);
        run_rd(12'h020, 8, 1'b1);

        // Zero-length start completes at once without touching RAM.
        reg_wr(RegLen, 32'h0);
        reg_wr(RegCtrl, 32'h1);
        check("len0_done", DW'(done), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("len0_no_sel", DW'(dma_sel), '0);
            @(posedge clk); #1;
        end
        reg_rd(RegStatus, rd);
        check("len0_status", rd, 32'h2);

        // Abort after two beats of an eight-beat read; busy writes to ADDR/LEN are ignored.
        reg_wr(RegAddr, 32'h020);
        reg_wr(RegLen, 32'd8);
        for (int k = 0; k < 8; k++) rd_q.push_back(DW'(k));
        m_ready = 1'b1;
        reg_wr(RegCtrl, 32'h1);
        reg_wr(RegAddr, 32'h777);
        reg_wr(RegLen, 32'd5);
        popped = 0;
        for (int c = 0; c < 50 && popped < 2; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) popped++;
            @(posedge clk); #1;
        end
        check("abort_reach", DW'(popped), 32'd2);
        reg_wr(RegCtrl, 32'h4);
        rd_q.delete();
        check("abort_m_valid", DW'(m_valid), '0);
        check("abort_done", DW'(done), '0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_quiet", DW'({m_valid, dma_sel}), '0);
        reg_rd(RegStatus, rd);
        check("abort_status", rd, 32'h0);
        reg_rd(RegAddr, rd);
        check("abort_addr_kept", rd, 32'h020);
        reg_rd(RegLen, rd);
        check("abort_len_kept", rd, 32'd8);

        // Reset in the middle of a read transfer.
        for (int k = 0; k < 8; k++) rd_q.push_back(DW'(k));
        reg_wr(RegCtrl, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        rd_q.delete();
        check("rstmid_ctrl", DW'({dma_sel, dma_we, s_ready, m_valid, done}), '0);
        check("rstmid_addr", DW'(dma_addr), '0);
        check("rstmid_m_data", m_data, '0);
        check("rstmid_rdata", ctrl_data_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b0;
        reg_rd(RegAddr, rd);
        check("rstmid_addr_reg", rd, 32'h0);
        reg_rd(RegStatus, rd);
        check("rstmid_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
